index_decoder: RTL and testbench
================================

INDEX_DECODER -- requirements
Module: index_decoder

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 2, giving the width of the binary index.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 2**IN_WIDTH, giving the number of decoded lines; legal range is 2..2**IN_WIDTH.
REQ-003 The block SHALL have port CLK  input  1  clock; single clock domain, all logic on rising edge.
REQ-004 The block SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port IN_VALID  input  1  index command present.
REQ-006 The block SHALL have port IN_READY  output  1  block accepts command this cycle.
REQ-007 The block SHALL have port IN  input  IN_WIDTH  binary index of command.
REQ-008 The block SHALL have port ACK_VALID  input  1  clear-request for a pending bit.
REQ-009 The block SHALL have port ACK_IDX  input  IN_WIDTH  index of bit to clear.
REQ-010 The block SHALL have port OUT  output  OUT_WIDTH  registered one-hot of last accepted index.
REQ-011 The block SHALL have port OUT_VALID  output  1  OUT holds an undelivered one-hot word.
REQ-012 The block SHALL have port OUT_READY  input  1  downstream consumes OUT this cycle.
REQ-013 The block SHALL have port PENDING  output  OUT_WIDTH  sticky mask of set-but-unacknowledged lines.
REQ-014 The block SHALL have port ERR  output  1  one-cycle pulse on out-of-range index.

Function
REQ-015 A command SHALL be accepted in a cycle where IN_VALID=1 and IN_READY=1 with RST_N=1.
REQ-016 IN_READY SHALL equal (!OUT_VALID || OUT_READY), combinationally; no other stall source.
REQ-017 An accepted in-range index k (k < OUT_WIDTH) SHALL load OUT with only bit k set and set OUT_VALID on the next edge; latency 1 cycle.
REQ-018 OUT and OUT_VALID SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 When OUT_VALID=1, OUT_READY=1 and no new command is accepted, OUT_VALID SHALL clear next edge; OUT SHALL clear to 0.
REQ-020 Consume and accept in the same cycle SHALL load the new word with OUT_VALID staying 1 (full throughput, one command per cycle).
REQ-021 An accepted index k >= OUT_WIDTH SHALL be consumed (handshake completes), SHALL NOT change OUT, OUT_VALID or PENDING, and SHALL pulse ERR for exactly one cycle next edge.
REQ-022 An accepted in-range index k SHALL set PENDING[k] next edge; already-set bits remain set.
REQ-023 ACK_VALID=1 with ACK_IDX=j < OUT_WIDTH SHALL clear PENDING[j] next edge; ACK_IDX >= OUT_WIDTH SHALL be ignored without ERR.
REQ-024 ACK_VALID SHALL be independent of handshake state and act in any cycle.
REQ-025 Simultaneous accepted set and ACK of the same bit SHALL leave that bit set (set wins); different bits SHALL both take effect.
REQ-026 OUT SHALL never have more than one bit set; PENDING MAY have any number set.
REQ-027 With OUT_WIDTH < 2**IN_WIDTH, range check SHALL use full IN_WIDTH comparison, no truncation.

Reset
REQ-028 With RST_N=0 at a rising edge, OUT SHALL be 0, OUT_VALID 0, PENDING 0, ERR 0 after that edge.
REQ-029 Reset SHALL override any command or ACK in the same cycle; a command presented during reset SHALL NOT be accepted for state purposes.
REQ-030 Reset mid-transfer (OUT_VALID=1, OUT_READY=0) SHALL discard the held word; IN_READY SHALL be 1 the first cycle after reset release.

Verification
REQ-031 Defaults: reset, then IN=2 with IN_VALID=1 one cycle, OUT_READY=1 -> next cycle OUT=4'b0100, OUT_VALID=1, PENDING=4'b0100; following cycle OUT_VALID=0.
REQ-032 Backpressure: OUT_READY=0, send IN=1 then IN=3 -> OUT=4'b0010 held, IN_READY=0 during second cycle, IN=3 not accepted until OUT_READY=1; then OUT=4'b1000.
REQ-033 Back-to-back: OUT_READY=1, IN=0,1,2,3 on consecutive cycles -> OUT sequence 0001,0010,0100,1000 with OUT_VALID continuously 1, PENDING=4'b1111.
REQ-034 Range: IN_WIDTH=3, OUT_WIDTH=5, IN=6 accepted -> ERR=1 for one cycle, OUT/OUT_VALID/PENDING unchanged; IN=4 -> OUT=5'b10000.
REQ-035 Set/ack collision: PENDING=4'b0110, same cycle IN=2 accepted and ACK_IDX=2, then ACK_IDX=1 -> PENDING 4'b0110, then 4'b0100.
REQ-036 Reset mid-operation: OUT_VALID=1, OUT_READY=0, PENDING=4'b1010, assert RST_N=0 one cycle -> OUT=0, OUT_VALID=0, PENDING=0, IN_READY=1 after release.

Source files
------------

// File: rtl/index_decoder.sv
// rtl/index_decoder.sv - registered index-to-one-hot decoder with valid/ready output and sticky pending mask
module index_decoder #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2**IN_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [IN_WIDTH-1:0]  IN,
  input  logic                 ACK_VALID,
  input  logic [IN_WIDTH-1:0]  ACK_IDX,
  output logic [OUT_WIDTH-1:0] OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [OUT_WIDTH-1:0] PENDING,
  output logic                 ERR
);

  // One extra bit so OUT_WIDTH == 2**IN_WIDTH is representable and indices compare untruncated.
  localparam logic [IN_WIDTH:0] LP_LIMIT = (IN_WIDTH+1)'(OUT_WIDTH);

  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_pending;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_in_range;
  logic                 w_ack_in_range;
  logic                 w_load;
  logic [OUT_WIDTH-1:0] w_set_mask;
  logic [OUT_WIDTH-1:0] w_clr_mask;

  assign IN_READY       = !r_out_valid || OUT_READY;
  assign w_accept       = IN_VALID && IN_READY;
  assign w_in_range     = {1'b0, IN} < LP_LIMIT;
  assign w_ack_in_range = {1'b0, ACK_IDX} < LP_LIMIT;
  assign w_load         = w_accept && w_in_range;

  assign w_set_mask = w_load ? (OUT_WIDTH'(1) << IN) : '0;
  assign w_clr_mask = (ACK_VALID && w_ack_in_range) ? (OUT_WIDTH'(1) << ACK_IDX) : '0;

  // Output word register: load on in-range accept, otherwise drop the word once consumed.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out       <= w_set_mask;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && OUT_READY) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end
  end

  // Pending mask: clear the acknowledged bit first, then OR in the new set so a collision keeps it set.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  // Error pulse: one cycle after an accepted out-of-range index.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_in_range;
    end
  end

  assign OUT       = r_out;
  assign OUT_VALID = r_out_valid;
  assign PENDING   = r_pending;
  assign ERR       = r_err;

endmodule

// File: tb/tb_index_decoder.sv
// tb/tb_index_decoder.sv - scoreboard testbench for index_decoder (default and 3-to-5 configurations)
module tb_index_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_in_valid, a_in_ready, a_ack_valid, a_out_valid, a_out_ready, a_err;
  logic [1:0] a_in, a_ack_idx;
  logic [3:0] a_out, a_pend;

  logic       b_rst_n, b_in_valid, b_in_ready, b_ack_valid, b_out_valid, b_out_ready, b_err;
  logic [2:0] b_in, b_ack_idx;
  logic [4:0] b_out, b_pend;

  index_decoder u_a (
    .CLK(clk), .RST_N(a_rst_n), .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .IN(a_in),
    .ACK_VALID(a_ack_valid), .ACK_IDX(a_ack_idx), .OUT(a_out), .OUT_VALID(a_out_valid),
    .OUT_READY(a_out_ready), .PENDING(a_pend), .ERR(a_err)
  );

  index_decoder #(.IN_WIDTH(3), .OUT_WIDTH(5)) u_b (
    .CLK(clk), .RST_N(b_rst_n), .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN(b_in),
    .ACK_VALID(b_ack_valid), .ACK_IDX(b_ack_idx), .OUT(b_out), .OUT_VALID(b_out_valid),
    .OUT_READY(b_out_ready), .PENDING(b_pend), .ERR(b_err)
  );

  typedef struct packed {
    logic [3:0] out;
    logic       ov;
    logic [3:0] pend;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_out, m_pend;
  logic       m_ov;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic rst_n, input logic iv, input logic [1:0] in,
                         input logic ordy, input logic av, input logic [1:0] aidx);
    a_rst_n = rst_n; a_in_valid = iv; a_in = in;
    a_out_ready = ordy; a_ack_valid = av; a_ack_idx = aidx;
    #1;
    check_eq("a_in_ready", {31'd0, a_in_ready}, {31'd0, (!m_ov || ordy)});
  endtask

  // Advance the model, queue its prediction, clock the DUT and compare against the popped entry.
  task automatic tick_a();
    exp_t       e;
    logic       acc;
    logic [3:0] set_m, clr_m;
    acc = a_rst_n && a_in_valid && (!m_ov || a_out_ready);
    if (!a_rst_n) begin
      m_out = 4'd0; m_ov = 1'b0; m_pend = 4'd0;
    end else begin
      set_m = acc ? (4'b0001 << a_in) : 4'b0000;
      clr_m = a_ack_valid ? (4'b0001 << a_ack_idx) : 4'b0000;
      if (acc) begin
        m_out = set_m; m_ov = 1'b1;
      end else if (m_ov && a_out_ready) begin
        m_out = 4'd0; m_ov = 1'b0;
      end
      m_pend = (m_pend & ~clr_m) | set_m;
    end
    e.out = m_out; e.ov = m_ov; e.pend = m_pend; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_eq("a_out",       {28'd0, a_out},       {28'd0, e.out});
    check_eq("a_out_valid", {31'd0, a_out_valid}, {31'd0, e.ov});
    check_eq("a_pending",   {28'd0, a_pend},      {28'd0, e.pend});
    check_eq("a_err",       {31'd0, a_err},       {31'd0, e.err});
  endtask

  task automatic step_b(input logic rst_n, input logic iv, input logic [2:0] in,
                        input logic ordy, input logic av, input logic [2:0] aidx);
    b_rst_n = rst_n; b_in_valid = iv; b_in = in;
    b_out_ready = ordy; b_ack_valid = av; b_ack_idx = aidx;
    @(posedge clk); #1;
  endtask

  initial begin
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in = 3'd0; b_out_ready = 1'b0; b_ack_valid = 1'b0; b_ack_idx = 3'd0;
    a_rst_n = 1'b0; a_in_valid = 1'b1; a_in = 2'd3; a_out_ready = 1'b0; a_ack_valid = 1'b0; a_ack_idx = 2'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_out",       {28'd0, a_out},       32'd0);
    check_eq("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check_eq("rst_pending",   {28'd0, a_pend},      32'd0);
    check_eq("rst_err",       {31'd0, a_err},       32'd0);
    m_out = 4'd0; m_ov = 1'b0; m_pend = 4'd0;

    // Basic decode and drain
    drive_a(1, 1, 2'd2, 1, 0, 0); tick_a();
    check_eq("basic_out", {28'd0, a_out}, 32'h4);
    check_eq("basic_pend", {28'd0, a_pend}, 32'h4);
    drive_a(1, 0, 2'd0, 1, 0, 0); tick_a();
    check_eq("basic_drain_ov", {31'd0, a_out_valid}, 32'd0);

    // Backpressure holds the word and stalls the next command
    drive_a(1, 1, 2'd1, 0, 0, 0); tick_a();
    drive_a(1, 1, 2'd3, 0, 0, 0);
    check_eq("bp_in_ready_low", {31'd0, a_in_ready}, 32'd0);
    tick_a();
    check_eq("bp_hold_out", {28'd0, a_out}, 32'h2);
    drive_a(1, 1, 2'd3, 1, 0, 0); tick_a();
    check_eq("bp_release_out", {28'd0, a_out}, 32'h8);
    drive_a(1, 0, 2'd0, 1, 0, 0); tick_a();

    // Back-to-back at full throughput
    drive_a(0, 0, 2'd0, 1, 0, 0); tick_a();
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 1, 2'(i), 1, 0, 0); tick_a();
      check_eq("b2b_out", {28'd0, a_out}, 32'd1 << i);
      check_eq("b2b_ov", {31'd0, a_out_valid}, 32'd1);
    end
    check_eq("b2b_pend", {28'd0, a_pend}, 32'hf);
    drive_a(1, 0, 2'd0, 1, 0, 0); tick_a();

    // Set/ack collision: set wins on the same bit, then a plain ack clears
    drive_a(0, 0, 2'd0, 1, 0, 0); tick_a();
    drive_a(1, 1, 2'd1, 1, 0, 0); tick_a();
    drive_a(1, 1, 2'd2, 1, 0, 0); tick_a();
    drive_a(1, 0, 2'd0, 1, 0, 0); tick_a();
    drive_a(1, 1, 2'd2, 1, 1, 2'd2); tick_a();
    check_eq("coll_pend", {28'd0, a_pend}, 32'h6);
    drive_a(1, 0, 2'd0, 1, 1, 2'd1); tick_a();
    check_eq("ack_pend", {28'd0, a_pend}, 32'h4);
    drive_a(1, 1, 2'd3, 1, 1, 2'd2); tick_a();
    check_eq("diff_bits_pend", {28'd0, a_pend}, 32'h8);

    // Reset while a word is held under backpressure
    drive_a(1, 1, 2'd1, 1, 0, 0); tick_a();
    drive_a(1, 1, 2'd3, 1, 0, 0); tick_a();
    drive_a(1, 0, 2'd0, 0, 0, 0); tick_a();
    check_eq("mid_pend", {28'd0, a_pend}, 32'ha);
    drive_a(0, 1, 2'd0, 0, 1, 2'd3); tick_a();
    drive_a(1, 0, 2'd0, 0, 0, 0);
    check_eq("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    check_eq("post_rst_out", {28'd0, a_out}, 32'd0);
    tick_a();

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive_a(($urandom_range(0, 39) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom));
      tick_a();
    end
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    // Narrow configuration: range check at IN_WIDTH=3, OUT_WIDTH=5
    step_b(0, 0, 3'd0, 0, 0, 3'd0);
    check_eq("b_rst_pend", {27'd0, b_pend}, 32'd0);
    step_b(1, 1, 3'd1, 1, 0, 3'd0);
    check_eq("b_out1", {27'd0, b_out}, 32'h02);
    step_b(1, 0, 3'd0, 1, 0, 3'd0);
    check_eq("b_drain_ov", {31'd0, b_out_valid}, 32'd0);
    b_rst_n = 1'b1; b_in_valid = 1'b1; b_in = 3'd6; b_out_ready = 1'b0;
    #1;
    check_eq("b_oor_ready", {31'd0, b_in_ready}, 32'd1);
    step_b(1, 1, 3'd6, 0, 0, 3'd0);
    check_eq("b_oor6_err", {31'd0, b_err}, 32'd1);
    check_eq("b_oor6_out", {27'd0, b_out}, 32'd0);
    check_eq("b_oor6_ov", {31'd0, b_out_valid}, 32'd0);
    check_eq("b_oor6_pend", {27'd0, b_pend}, 32'h02);
    step_b(1, 0, 3'd0, 0, 0, 3'd0);
    check_eq("b_err_one_cycle", {31'd0, b_err}, 32'd0);
    step_b(1, 1, 3'd5, 0, 0, 3'd0);
    check_eq("b_oor5_err", {31'd0, b_err}, 32'd1);
    check_eq("b_oor5_ov", {31'd0, b_out_valid}, 32'd0);
    step_b(1, 0, 3'd0, 0, 1, 3'd7);
    check_eq("b_ack_oor_err", {31'd0, b_err}, 32'd0);
    check_eq("b_ack_oor_pend", {27'd0, b_pend}, 32'h02);
    step_b(1, 0, 3'd0, 0, 1, 3'd1);
    check_eq("b_ack1_pend", {27'd0, b_pend}, 32'h00);
    step_b(1, 1, 3'd4, 0, 0, 3'd0);
    check_eq("b_in4_out", {27'd0, b_out}, 32'h10);
    check_eq("b_in4_ov", {31'd0, b_out_valid}, 32'd1);
    check_eq("b_in4_err", {31'd0, b_err}, 32'd0);
    check_eq("b_in4_pend", {27'd0, b_pend}, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
